// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath (master) reports stage contents; the controller (slave) returns enables, bubbles and stats.
interface pipe_hazard_ctrl_if;
  logic [4:0]  ID_rs_addr;
  logic [4:0]  ID_rt_addr;
  logic        ID_rs_used;
  logic        ID_rt_used;
  logic        ID_branch_taken;
  logic [4:0]  EXE_RF_waddr;
  logic        EXE_RF_W_ena;
  logic        EXE_md;
  logic [4:0]  MEM_RF_waddr;
  logic        MEM_RF_W_ena;

  logic        pc_W_ena;
  logic        FD_W_ena;
  logic        FD_flush;
  logic        DE_W_ena;
  logic        DE_bubble;
  logic        stall;
  logic        EM_bubble;
  logic        md_start;
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;

  modport slave (
    input  ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used, ID_branch_taken,
    input  EXE_RF_waddr, EXE_RF_W_ena, EXE_md, MEM_RF_waddr, MEM_RF_W_ena,
    output pc_W_ena, FD_W_ena, FD_flush, DE_W_ena, DE_bubble, stall,
    output EM_bubble, md_start, bubble_cnt, flush_cnt
  );

  modport master (
    output ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used, ID_branch_taken,
    output EXE_RF_waddr, EXE_RF_W_ena, EXE_md, MEM_RF_waddr, MEM_RF_W_ena,
    input  pc_W_ena, FD_W_ena, FD_flush, DE_W_ena, DE_bubble, stall,
    input  EM_bubble, md_start, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush scheduler for a 5-stage pipeline without forwarding.
// Handles RAW hazards against EXE/MEM writers, multi-cycle mult/div occupancy and taken-branch flushes.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {RUN, MD_BUSY} state_e;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       bubble_cnt_q, bubble_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;

  logic hz_exe, hz_mem, raw;
  logic md_hold, md_start_raw;
  logic pc_w_ena, fd_w_ena, fd_flush, de_w_ena, de_bubble, stall, em_bubble, md_start;

  // Register $0 is never a real destination; WB writers are covered by the write-first RF.
  assign hz_exe = bus.EXE_RF_W_ena && (bus.EXE_RF_waddr != 5'd0) &&
                  ((bus.ID_rs_used && (bus.ID_rs_addr == bus.EXE_RF_waddr)) ||
                   (bus.ID_rt_used && (bus.ID_rt_addr == bus.EXE_RF_waddr)));
  assign hz_mem = bus.MEM_RF_W_ena && (bus.MEM_RF_waddr != 5'd0) &&
                  ((bus.ID_rs_used && (bus.ID_rs_addr == bus.MEM_RF_waddr)) ||
                   (bus.ID_rt_used && (bus.ID_rt_addr == bus.MEM_RF_waddr)));
  assign raw    = hz_exe || hz_mem;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_hold      = 1'b0;
    md_start_raw = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.EXE_md) begin
          md_hold      = 1'b1;
          md_start_raw = 1'b1;
          state_d      = MD_BUSY;
          cnt_d        = MD_LOAD;
        end
      end
      MD_BUSY: begin
        // The cnt==0 cycle is the release cycle: EXE_md still high here is the same op.
        if (cnt_q != '0) begin
          md_hold = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_w_ena  = 1'b0;
    fd_w_ena  = 1'b0;
    fd_flush  = 1'b0;
    de_w_ena  = 1'b0;
    de_bubble = 1'b0;
    stall     = 1'b0;
    em_bubble = 1'b0;
    md_start  = 1'b0;
    if (rst) begin
      md_start = md_start_raw;
      if (md_hold) begin
        stall     = 1'b1;
        em_bubble = 1'b1;
        de_w_ena  = 1'b1;
      end else if (raw) begin
        de_w_ena  = 1'b1;
        de_bubble = 1'b1;
      end else if (bus.ID_branch_taken) begin
        pc_w_ena  = 1'b1;
        fd_w_ena  = 1'b1;
        de_w_ena  = 1'b1;
        fd_flush  = 1'b1;
      end else begin
        pc_w_ena  = 1'b1;
        fd_w_ena  = 1'b1;
        de_w_ena  = 1'b1;
      end
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + 32'(de_bubble);
    flush_cnt_d  = flush_cnt_q + 32'(fd_flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.pc_W_ena   = pc_w_ena;
  assign bus.FD_W_ena   = fd_w_ena;
  assign bus.FD_flush   = fd_flush;
  assign bus.DE_W_ena   = de_w_ena;
  assign bus.DE_bubble  = de_bubble;
  assign bus.stall      = stall;
  assign bus.EM_bubble  = em_bubble;
  assign bus.md_start   = md_start;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall scheduler for the static (no-forwarding) 5-stage pipeline.
- Watches ID source registers against pending writers in EXE and MEM, and inserts bubbles into the Decode→Execute register while holding PC and IF/ID.
- Sequences multi-cycle mult/div occupancy of EXE by freezing the DE register and bubbling EXE→MEM.
- Flushes IF/ID on taken branches resolved in ID.

Parameters:
- MD_CYCLES, 4, total cycles a mult/div instruction occupies EXE (legal range 2..16).
- CNT_W, 4, width of the mult/div down-counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- ID_rs_addr  in  5  rs field of instruction in ID
- ID_rt_addr  in  5  rt field of instruction in ID
- ID_rs_used  in  1  ID instruction reads rs
- ID_rt_used  in  1  ID instruction reads rt
- ID_branch_taken  in  1  branch/jump in ID resolved taken this cycle
- EXE_RF_waddr  in  5  destination register of instruction in EXE
- EXE_RF_W_ena  in  1  EXE instruction writes RF
- EXE_md  in  1  EXE instruction is mult/div
- MEM_RF_waddr  in  5  destination register of instruction in MEM
- MEM_RF_W_ena  in  1  MEM instruction writes RF
- pc_W_ena  out  1  PC update enable
- FD_W_ena  out  1  IF/ID register write enable
- FD_flush  out  1  load NOP into IF/ID at next edge
- DE_W_ena  out  1  DE register write enable
- DE_bubble  out  1  zero ID control signals entering DE (insert NOP)
- stall  out  1  hold DE register (drives DE stall input)
- EM_bubble  out  1  insert NOP into EXE/MEM register
- md_start  out  1  one-cycle start pulse to mult/div unit
- bubble_cnt  out  32  count of cycles with DE_bubble=1
- flush_cnt  out  32  count of cycles with FD_flush=1

Behaviour:
- Reset (rst=0, async): state=RUN, counter=0, bubble_cnt=flush_cnt=0. All combinational outputs are forced to 0 while rst=0: enables, stall, bubbles, flush, md_start.
- FSM states: RUN, MD_BUSY.
- hz_exe: EXE_RF_W_ena && EXE_RF_waddr!=0 && ((ID_rs_used && rs==EXE_RF_waddr) || (ID_rt_used && rt==EXE_RF_waddr)).
- hz_mem: the same condition against the MEM_* inputs.
- The RF is write-first, so a WB-stage writer is not a hazard.
- raw = hz_exe || hz_mem. This is a combinational re-check every cycle.
  - An EXE hazard yields 2 bubbles; a MEM hazard yields 1 bubble. This falls out naturally as the writer advances.
- md_hold = (state==RUN && EXE_md) || (state==MD_BUSY && counter!=0).
- Priority, highest first: md_hold > raw > ID_branch_taken.
  - md_hold: stall=1, EM_bubble=1, pc_W_ena=0, FD_W_ena=0, DE_W_ena=1, DE_bubble=0, FD_flush=0.
  - raw (no md_hold): pc_W_ena=0, FD_W_ena=0, DE_W_ena=1, DE_bubble=1, stall=0, FD_flush=0. A taken branch is suppressed because its operands are not ready.
  - ID_branch_taken only: all enables 1, FD_flush=1, no bubble.
  - None of the above: pc_W_ena=FD_W_ena=DE_W_ena=1; stall, bubbles and flush are 0.
- Transition RUN→MD_BUSY: in RUN with EXE_md=1.
  - md_start=1 for that cycle only.
  - counter loads MD_CYCLES-2.
- MD_BUSY: counter decrements each cycle while !=0.
  - In the cycle counter==0, stall=0 and normal priority (raw/branch) applies.
  - MD_BUSY→RUN at that edge.
  - EXE_md still high in that cycle does not retrigger.
- Total EXE occupancy of a mult/div is exactly MD_CYCLES cycles.
- Back-to-back mult/div: the second one enters EXE after the release edge, state is RUN, and it triggers normally.
- Counters: bubble_cnt and flush_cnt increment at the edge after a cycle with DE_bubble=1 (resp. FD_flush=1). Both are 32-bit and wrap modulo 2^32.
- Reset asserted mid-MD_BUSY aborts immediately to RUN/0. md_start is not re-issued until EXE_md is seen in RUN after reset.

Test Plan:
- Load-use chain: EXE writes $5 (W_ena=1), ID reads rs=$5 → DE_bubble=1 for 2 cycles, pc_W_ena=FD_W_ena=0, bubble_cnt=2, then normal flow.
- Writer to $0: EXE_RF_waddr=0, W_ena=1, ID rs=0 used → no bubble, all enables 1.
- MEM-only hazard on rt=$7 with ID_rt_used=1, ID_rs_used=0 → exactly 1 bubble; same address on rs with rs_used=0 → no bubble.
- MD_CYCLES=4, EXE_md=1 → md_start one pulse, stall=1 and EM_bubble=1 for 3 cycles, released on 4th; concurrent ID hazard ignored until release.
- Taken branch with hz_exe=1 → no flush, bubble; next cycle hazard clears (writer in MEM still → bubble), then flush asserted once, flush_cnt=1.
- Assert rst=0 during MD_BUSY counter=2 → outputs 0 immediately; after release, state RUN, counters 0, EXE_md=1 gives new md_start.
